// File: rtl/pingpong_reg_bank_pkg.sv
// Shared defaults and state encoding for the double-buffered display register store.
package pingpong_reg_bank_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 4;
  localparam logic        DISP_BANK_RST = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } pend_state_e;

endpackage

// File: rtl/pingpong_reg_bank_reg_bank.sv
// One register bank: flop array with synchronous write and combinational read.
module pingpong_reg_bank_reg_bank #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pingpong_reg_bank.sv
// Double-buffered 16x8 store: writer fills one bank, display reads the other; swaps commit on frame_start.
module pingpong_reg_bank
  import pingpong_reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic              frame_start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              disp_bank,
  output logic              swap_pending,
  output logic              overrun,
  output logic              collision
);

  logic              sel_q;
  logic              toggle;
  pend_state_e       state;
  logic [DATA_W-1:0] bank_rd [2];

  pingpong_reg_bank_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && !wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (bank_rd[0])
  );

  pingpong_reg_bank_reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (bank_rd[1])
  );

  assign toggle       = wr_sel ^ sel_q;
  assign swap_pending = (state == PENDING);

  // A toggle coinciding with frame_start is consumed by the commit, so it can never raise overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 1'b0;
      state     <= IDLE;
      disp_bank <= DISP_BANK_RST;
      overrun   <= 1'b0;
    end else begin
      sel_q <= wr_sel;
      if (frame_start && (toggle || state == PENDING)) begin
        disp_bank <= ~wr_sel;
        state     <= IDLE;
      end else if (toggle) begin
        if (state == PENDING) overrun <= 1'b1;
        state <= PENDING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
    end else if (wr_en && (wr_sel == disp_bank)) begin
      collision <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= bank_rd[disp_bank];
    end
  end

endmodule

// File: tb/tb_pingpong_reg_bank.sv
// Directed bench: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_pingpong_reg_bank;

  logic       clk;
  logic       rst_n;
  logic [7:0] wr_data;
  logic [3:0] wr_addr;
  logic       wr_en;
  logic       wr_sel;
  logic       frame_start;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       disp_bank;
  logic       swap_pending;
  logic       overrun;
  logic       collision;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  exp_q [$];

  pingpong_reg_bank #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .frame_start  (frame_start),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .disp_bank    (disp_bank),
    .swap_pending (swap_pending),
    .overrun      (overrun),
    .collision    (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic db, input logic sp, input logic ov, input logic co);
    chk({tag, "_disp_bank"}, disp_bank, db);
    chk({tag, "_swap_pending"}, swap_pending, sp);
    chk({tag, "_overrun"}, overrun, ov);
    chk({tag, "_collision"}, collision, co);
  endtask

  // Issue one read; rd_en is left high so consecutive calls form back-to-back reads.
  task automatic rd(input logic [3:0] addr, input logic [7:0] exp);
    rd_en   = 1'b1;
    rd_addr = addr;
    exp_q.push_back(exp);
    step();
    chk("rd_valid_latency", rd_valid, 1);
  endtask

  task automatic rd_idle();
    rd_en = 1'b0;
    step();
    chk("rd_valid_idle", rd_valid, 0);
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_valid", 1, 0);
        else chk("sb_rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; wr_data = '0; wr_addr = '0; wr_en = 1'b0; wr_sel = 1'b0;
    frame_start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    #12;
    flags("rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) rd(4'(i), 8'h00);
    rd_idle();
    flags("post_rst_reads", 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill bank 0, complete it, commit on frame_start.
    wr(1'b0, 4'd3, 8'hA5);
    chk("wr_bank0_no_collision", collision, 0);
    wr_sel = 1'b1;
    step();
    flags("toggle_pending", 1'b1, 1'b1, 1'b0, 1'b0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    flags("commit", 1'b0, 1'b0, 1'b0, 1'b0);
    rd(4'd3, 8'hA5);
    rd_idle();

    // Toggle together with frame_start: immediate commit, never pending.
    wr_sel = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    flags("same_cycle", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("same_cycle_settled_pending", swap_pending, 0);

    // Two toggles before a frame: overrun.
    wr_sel = 1'b1;
    step();
    flags("ovr_first", 1'b1, 1'b1, 1'b0, 1'b0);
    wr_sel = 1'b0;
    step();
    flags("ovr_second", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk("ovr_sticky", overrun, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    flags("ovr_commit", 1'b1, 1'b0, 1'b1, 1'b0);

    // Write into displayed bank 1 while reading the same address.
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
    rd(4'd7, 8'h00);
    wr_en = 1'b0;
    chk("collision_set", collision, 1);
    rd(4'd7, 8'h3C);
    rd_idle();
    chk("collision_sticky", collision, 1);

    // Reset in the middle of a pending swap with data held.
    wr(1'b1, 4'd5, 8'hFF);
    rd(4'd5, 8'hFF);
    rd_idle();
    wr_sel = 1'b0;
    step();
    chk("pre_rst_pending", swap_pending, 1);
    #2;
    rst_n = 1'b0;
    #1;
    flags("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("async_rst_rd_data", rd_data, 0);
    chk("async_rst_rd_valid", rd_valid, 0);
    #10;
    rst_n = 1'b1;
    step();
    rd(4'd5, 8'h00);
    rd(4'd7, 8'h00);
    rd_idle();
    flags("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) step();
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
